// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data ports; request-to-ack is 1+MEM_LAT cycles.
// A losing or late port simply keeps its request up and sees stall until its own ack; one access in flight at a time.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 2,
  parameter int DATA_PRIO = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_wmask,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_t             state, state_nxt;
  logic               grant_dm, last_dm, kill_pend, lat_we;
  logic               pick_dm, capture, any_req;
  logic [CNT_W-1:0]   cnt;

  assign any_req = if_req | dm_req;

  always_comb begin
    pick_dm = dm_req;
    if (if_req && dm_req) pick_dm = (DATA_PRIO != 0) ? 1'b1 : !last_dm;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = (MEM_LAT == 1) ? RESP : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data is sampled on the edge that ends the last latency cycle.
  assign capture = (state_nxt == RESP) && (state != RESP);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      grant_dm  <= 1'b0;
      last_dm   <= 1'b0;
      kill_pend <= 1'b0;
      lat_we    <= 1'b0;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          grant_dm  <= pick_dm;
          mem_en    <= 1'b1;
          mem_we    <= pick_dm & dm_we;
          lat_we    <= pick_dm & dm_we;
          mem_addr  <= pick_dm ? dm_addr : if_addr;
          mem_wdata <= pick_dm ? dm_wdata : '0;
          mem_wmask <= pick_dm ? dm_wmask : 4'h0;
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= CNT_W'(MEM_LAT - 1);
        end
        WAIT:    cnt <= cnt - CNT_W'(1);
        RESP: begin
          last_dm   <= grant_dm;
          kill_pend <= 1'b0;
        end
        default: ;
      endcase
      if ((state == ISSUE || state == WAIT) && !grant_dm && if_kill) kill_pend <= 1'b1;
      if (capture && !lat_we) begin
        if (grant_dm) dm_rdata <= mem_rdata;
        else          if_rdata <= mem_rdata;
      end
    end
  end

  assign if_ack = (state == RESP) && !grant_dm && !(if_kill || kill_pend);
  assign dm_ack = (state == RESP) && grant_dm;
  // Stalls are held low while reset is asserted so every output is quiet in reset.
  assign if_stall = rstn & if_req & ~if_ack;
  assign dm_stall = rstn & dm_req & ~dm_ack;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a data-priority instance and a round-robin instance share stimulus; each sees a small read-only memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn, if_req, if_kill, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_wmask;

  logic        p_if_ack, p_dm_ack, p_mem_en, p_mem_we, p_if_stall, p_dm_stall, p_busy;
  logic [31:0] p_if_rdata, p_dm_rdata, p_mem_addr, p_mem_wdata, p_mem_rdata;
  logic [3:0]  p_mem_wmask;
  logic        r_if_ack, r_dm_ack, r_mem_en, r_mem_we, r_if_stall, r_dm_stall, r_busy;
  logic [31:0] r_if_rdata, r_dm_rdata, r_mem_addr, r_mem_wdata, r_mem_rdata;
  logic [3:0]  r_mem_wmask;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    case (a)
      32'h0000_0400: rd = 32'h0050_0093;
      32'h0000_0010: rd = 32'h1111_1111;
      default:       rd = a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  assign p_mem_rdata = rd(p_mem_addr);
  assign r_mem_rdata = rd(r_mem_addr);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .DATA_PRIO(1)) u_dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_ack(p_if_ack), .if_rdata(p_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wmask(dm_wmask),
    .dm_ack(p_dm_ack), .dm_rdata(p_dm_rdata),
    .mem_en(p_mem_en), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
    .mem_wmask(p_mem_wmask), .mem_rdata(p_mem_rdata),
    .if_stall(p_if_stall), .dm_stall(p_dm_stall), .busy(p_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .DATA_PRIO(0)) u_rr (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_ack(r_if_ack), .if_rdata(r_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wmask(dm_wmask),
    .dm_ack(r_dm_ack), .dm_rdata(r_dm_rdata),
    .mem_en(r_mem_en), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
    .mem_wmask(r_mem_wmask), .mem_rdata(r_mem_rdata),
    .if_stall(r_if_stall), .dm_stall(r_dm_stall), .busy(r_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rstn, if_req, if_kill, dm_req;
    logic        en, we, if_ack, dm_ack, if_stall, dm_stall, busy;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl [20];

  initial begin
    rstn = 1'b0; if_req = 1'b0; if_kill = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 32'h400; dm_addr = 32'h10; dm_wdata = 32'h0; dm_wmask = 4'h0;

    //          rst ifr kil dmr  en we ia da is ds bsy  addr
    tbl[0]  = '{1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0};
    tbl[2]  = '{1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 32'h0};
    tbl[3]  = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 32'h10};
    tbl[4]  = '{1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 32'h10};
    tbl[5]  = '{1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 32'h10};
    tbl[6]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'h10};
    tbl[7]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 32'h400};
    tbl[8]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 32'h400};
    tbl[9]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 32'h400};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h400};
    tbl[11] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'h400};
    tbl[12] = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 32'h400};
    tbl[13] = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 32'h400};
    tbl[14] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 32'h400};
    tbl[15] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h400};
    tbl[16] = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 32'h400};
    tbl[17] = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 32'h10};
    tbl[18] = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h10};
    tbl[19] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0};

    // Reset, tie under data priority, single fetch, killed fetch, reset during WAIT.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      rstn = tbl[i].rstn; if_req = tbl[i].if_req; if_kill = tbl[i].if_kill; dm_req = tbl[i].dm_req;
      @(negedge clk);
      chk($sformatf("c%0d mem_en", i),   p_mem_en,   tbl[i].en);
      chk($sformatf("c%0d mem_we", i),   p_mem_we,   tbl[i].we);
      chk($sformatf("c%0d mem_addr", i), p_mem_addr, tbl[i].addr);
      chk($sformatf("c%0d if_ack", i),   p_if_ack,   tbl[i].if_ack);
      chk($sformatf("c%0d dm_ack", i),   p_dm_ack,   tbl[i].dm_ack);
      chk($sformatf("c%0d if_stall", i), p_if_stall, tbl[i].if_stall);
      chk($sformatf("c%0d dm_stall", i), p_dm_stall, tbl[i].dm_stall);
      chk($sformatf("c%0d busy", i),     p_busy,     tbl[i].busy);
      if (i == 1) chk("reset if_rdata", p_if_rdata, 32'h0);
      if (i == 5) chk("load dm_rdata", p_dm_rdata, 32'h1111_1111);
      if (i == 9) chk("fetch if_rdata", p_if_rdata, 32'h0050_0093);
      if (i == 19) begin
        chk("midreset dm_rdata", p_dm_rdata, 32'h0);
        chk("midreset mem_wmask", {28'h0, p_mem_wmask}, 32'h0);
      end
    end

    // Store: ISSUE carries the write, dm_ack two cycles later, dm_rdata untouched.
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEAD_BEEF; dm_wmask = 4'hF;
    @(negedge clk);
    chk("st idle busy", p_busy, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("st mem_en", p_mem_en, 1'b1);
    chk("st mem_we", p_mem_we, 1'b1);
    chk("st mem_addr", p_mem_addr, 32'h20);
    chk("st mem_wdata", p_mem_wdata, 32'hDEAD_BEEF);
    chk("st mem_wmask", {28'h0, p_mem_wmask}, 32'hF);
    @(posedge clk); @(negedge clk);
    chk("st wait mem_we", p_mem_we, 1'b0);
    chk("st wait dm_ack", p_dm_ack, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("st dm_ack", p_dm_ack, 1'b1);
    chk("st dm_rdata", p_dm_rdata, 32'h0);
    @(posedge clk); #1;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h10; dm_wdata = 32'h0; dm_wmask = 4'h0;

    // Both ports request continuously after reset: round-robin alternates, priority starves IF.
    rstn = 1'b0; if_req = 1'b1; dm_req = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      chk($sformatf("rr k%0d dm_ack", k), r_dm_ack, (k == 3 || k == 11));
      chk($sformatf("rr k%0d if_ack", k), r_if_ack, (k == 7 || k == 15));
      chk($sformatf("pr k%0d dm_ack", k), p_dm_ack, (k % 4 == 3));
      chk($sformatf("pr k%0d if_stall", k), p_if_stall, 1'b1);
      if (k == 7) chk("rr if_rdata", r_if_rdata, 32'h0050_0093);
      if (k == 3) chk("rr dm_rdata", r_dm_rdata, 32'h1111_1111);
      @(posedge clk); #1;
    end
    if_req = 1'b0; dm_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters of the pipelined CPU: the instruction-fetch port (IF) and the data-memory port (MEM stage).
- Grants one access at a time and sequences the memory through issue, wait and response phases for a fixed latency.
- Returns read data with a one-cycle acknowledge pulse, and gives the pipeline per-port stall signals.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, memory read latency in cycles; minimum 1; the ISSUE cycle counts as cycle 1
DATA_PRIO, 1, 1 = data port always wins a tie; 0 = round-robin on ties

Ports:
clk  in  1  clock; all logic updates on the rising edge
rstn  in  1  reset, synchronous, active-low
if_req  in  1  fetch request; held high with if_addr stable until if_ack or if_kill
if_addr  in  ADDR_W  fetch address
if_kill  in  1  flush of the in-flight fetch (branch taken)
if_ack  out  1  one-cycle pulse; if_rdata is valid in the same cycle
if_rdata  out  DATA_W  fetched instruction, registered
dm_req  in  1  data request; held high with all dm_* inputs stable until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_wmask  in  4  byte-enable for stores, decoded from DMType upstream
dm_ack  out  1  one-cycle pulse
dm_rdata  out  DATA_W  load data, registered
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wmask  out  4  memory byte-enable
mem_rdata  in  DATA_W  memory read data
if_stall  out  1  if_req & ~if_ack
dm_stall  out  1  dm_req & ~dm_ack
busy  out  1  state != IDLE

Behaviour:
- Reset: rstn sampled low at a rising edge sets:
  - state=IDLE, last_grant=IF;
  - mem_en, mem_we, mem_wmask, mem_addr, mem_wdata = 0;
  - if_ack, dm_ack = 0; if_rdata, dm_rdata = 0; kill_pend=0.
- Reset mid-operation: the in-flight access is abandoned and no ack is issued. Requesters must re-present their request.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - One request present: grant it.
  - Both present: DATA_PRIO=1 grants DM; DATA_PRIO=0 grants the port not equal to last_grant (DM wins the first tie after reset).
  - On a grant, latch the grant and the port fields, then go to ISSUE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we=latched we (IF is always 0); mem_addr, mem_wdata and mem_wmask driven from the latch (IF mask=0).
  - Load counter with MEM_LAT-1.
  - MEM_LAT=1 goes to RESP; otherwise goes to WAIT.
- WAIT (MEM_LAT-1 cycles): mem_en=0, mem_we=0, mem_addr held. Decrement; go to RESP when the count reaches 1.
- Data capture: mem_rdata is captured at the edge ending the MEM_LAT-th cycle counted from ISSUE.
  - Loads update the granted port's rdata register.
  - Stores leave dm_rdata unchanged.
- RESP (1 cycle):
  - Pulse the granted port's ack, unless the grant is IF and kill_pend=1.
  - Update last_grant, clear kill_pend, go to IDLE.
- Request-to-ack latency: a request sampled in IDLE at cycle T is acked in cycle T+1+MEM_LAT. Peak throughput is one access per MEM_LAT+2 cycles.
- if_kill:
  - Asserted in ISSUE, WAIT or RESP while the grant is IF: sets kill_pend (RESP uses if_kill | kill_pend). The memory access completes, if_ack is suppressed and if_rdata is still updated.
  - if_kill in IDLE has no effect. if_kill never affects a DM grant.
- Port behaviour during another port's access: a port that raises req while the other port's access is in progress waits. Its stall stays high until its own ack.
- Simultaneous ack and new request: requests are not sampled in RESP. A requester may re-raise req in the ack cycle, and it is sampled in the following IDLE cycle.

Test Plan:
- Reset, MEM_LAT=2: rstn low 2 cycles with if_req=dm_req=1 -> all outputs 0, busy=0. The first ISSUE occurs 1 cycle after rstn rises.
- Single fetch: if_req with if_addr=0x00000400 sampled at T -> mem_en=1, mem_addr=0x400, mem_we=0 in T+1. Memory returns 0x00500093 -> if_ack=1 and if_rdata=0x00500093 in T+3; if_stall=1 in T..T+2.
- Tie, DATA_PRIO=1: if_req and dm_req (load 0x10) both high at T -> DM acked at T+3. IF is issued at T+5 and acked at T+7; if_stall stays high throughout.
- Tie round-robin, DATA_PRIO=0: both ports request continuously -> grants alternate DM, IF, DM, IF, with each ack 4 cycles apart.
- Store: dm_we=1, dm_addr=0x20, dm_wdata=0xDEADBEEF, dm_wmask=0xF -> mem_en=mem_we=1 with those values in the ISSUE cycle. dm_ack arrives 2 cycles later; dm_rdata is unchanged.
- Kill and reset mid-operation:
  - if_kill pulsed in WAIT of a fetch -> no if_ack; the arbiter is back in IDLE the cycle after RESP.
  - rstn low during WAIT -> no ack, state returns to IDLE.
